// File: rtl/flow_redirect_ctrl_pkg.sv
// Shared types and defaults for the flow redirect controller.
package flow_redirect_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PEND   = 2'd1,
    SQUASH = 2'd2
  } flow_state_t;

  localparam int FLUSH_CYCLES_DEF = 2;

endpackage

// File: rtl/flow_redirect_ctrl_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/flow_redirect_ctrl.sv
// Captures EX-stage redirects, offers them to fetch and squashes wrong-path stages.
// Optional statistics counters are built only when BR_STATS_EN is defined.
//
//   state  | meaning
//   IDLE   | no redirect outstanding; a flow_change is latched and flushed at once
//   PEND   | redirect offered to fetch, waiting for fetch_rdy
//   SQUASH | redirect accepted, flushing until wrong-path work has drained
module flow_redirect_ctrl
  import flow_redirect_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flow_change,
  input  logic [31:0]      br_addr,
  input  logic             fetch_rdy,
  output logic             redirect_vld,
  output logic [31:0]      redirect_pc,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             busy,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic [CNT_W-1:0] squash_cnt
);

  flow_state_t state, state_nxt;
  logic [31:0] sq_cnt, sq_cnt_nxt;
  logic [31:0] pc_nxt;
  logic        flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      sq_cnt      <= '0;
      redirect_pc <= '0;
    end else begin
      state       <= state_nxt;
      sq_cnt      <= sq_cnt_nxt;
      redirect_pc <= pc_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    sq_cnt_nxt = sq_cnt;
    pc_nxt     = redirect_pc;
    flush      = 1'b0;
    unique case (state)
      IDLE: begin
        // Only flush that is not decoded from state; masked so reset drives it low.
        flush = flow_change & ~rst;
        if (flow_change) begin
          pc_nxt    = br_addr;
          state_nxt = PEND;
        end
      end
      PEND: begin
        flush = 1'b1;
        if (fetch_rdy) begin
          if (FLUSH_CYCLES == 1) begin
            state_nxt = IDLE;
          end else begin
            sq_cnt_nxt = 32'(FLUSH_CYCLES - 1);
            state_nxt  = SQUASH;
          end
        end
      end
      SQUASH: begin
        flush      = 1'b1;
        sq_cnt_nxt = sq_cnt - 32'd1;
        if (sq_cnt == 32'd1) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign redirect_vld = (state == PEND);
  assign busy         = (state != IDLE);
  assign flush_ifid   = flush;
  assign flush_idex   = flush;

`ifdef BR_STATS_EN
  logic xfer;
  assign xfer = redirect_vld & fetch_rdy;

  sat_cnt #(.W(CNT_W)) u_redirect_cnt (
    .clk (clk),
    .rst (rst),
    .inc (xfer),
    .clr (1'b0),
    .cnt (redirect_cnt)
  );

  sat_cnt #(.W(CNT_W)) u_squash_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush_idex),
    .clr (1'b0),
    .cnt (squash_cnt)
  );
`else
  assign redirect_cnt = '0;
  assign squash_cnt   = '0;
`endif

endmodule

// File: tb/tb_flow_redirect_ctrl.sv
// Bench for flow_redirect_ctrl: three instances (FLUSH_CYCLES 2, 1, 4) driven in lockstep.
module tb_flow_redirect_ctrl;

  localparam int NI   = 3;
  localparam int CW   = 4;
  localparam int FL0  = 2;
  localparam int FL1  = 1;
  localparam int FL2  = 4;
  localparam int CMAX = (1 << CW) - 1;
`ifdef BR_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  int flcyc[NI] = '{FL0, FL1, FL2};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flow_change = 1'b0;
  logic        fetch_rdy = 1'b0;
  logic [31:0] br_addr = '0;

  logic          vld [NI];
  logic [31:0]   pc  [NI];
  logic          fi  [NI];
  logic          fx  [NI];
  logic          bsy [NI];
  logic [CW-1:0] rc  [NI];
  logic [CW-1:0] sc  [NI];

  always #5 clk = ~clk;

  flow_redirect_ctrl #(.FLUSH_CYCLES(FL0), .CNT_W(CW)) u_dut0 (
    .clk(clk), .rst(rst), .flow_change(flow_change), .br_addr(br_addr), .fetch_rdy(fetch_rdy),
    .redirect_vld(vld[0]), .redirect_pc(pc[0]), .flush_ifid(fi[0]), .flush_idex(fx[0]),
    .busy(bsy[0]), .redirect_cnt(rc[0]), .squash_cnt(sc[0]));

  flow_redirect_ctrl #(.FLUSH_CYCLES(FL1), .CNT_W(CW)) u_dut1 (
    .clk(clk), .rst(rst), .flow_change(flow_change), .br_addr(br_addr), .fetch_rdy(fetch_rdy),
    .redirect_vld(vld[1]), .redirect_pc(pc[1]), .flush_ifid(fi[1]), .flush_idex(fx[1]),
    .busy(bsy[1]), .redirect_cnt(rc[1]), .squash_cnt(sc[1]));

  flow_redirect_ctrl #(.FLUSH_CYCLES(FL2), .CNT_W(CW)) u_dut2 (
    .clk(clk), .rst(rst), .flow_change(flow_change), .br_addr(br_addr), .fetch_rdy(fetch_rdy),
    .redirect_vld(vld[2]), .redirect_pc(pc[2]), .flush_ifid(fi[2]), .flush_idex(fx[2]),
    .busy(bsy[2]), .redirect_cnt(rc[2]), .squash_cnt(sc[2]));

  // Reference model: "a redirect is waiting" flag, target, and flush cycles still owed.
  bit          m_pend [NI];
  logic [31:0] m_pc   [NI];
  int          m_left [NI];
  int          m_rc   [NI];
  int          m_sc   [NI];

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s[dut%0d] @%0t: got %h expected %h", name, idx, $time, act, exp);
    end
  endtask

  function automatic int stat_exp(input int v);
    if (!STATS) return 0;
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_pend[i] = 1'b0;
      m_pc[i]   = '0;
      m_left[i] = 0;
      m_rc[i]   = 0;
      m_sc[i]   = 0;
    end
  endtask

  // Drive one cycle's inputs at the falling edge, check all instances, then advance the model.
  task automatic step(input logic fc, input logic [31:0] a, input logic rdy, input logic r);
    @(negedge clk);
    flow_change = fc;
    br_addr     = a;
    fetch_rdy   = rdy;
    rst         = r;
    #1;
    if (r) model_reset();
    for (int i = 0; i < NI; i++) begin
      logic e_vld, e_fl, e_busy;
      e_vld  = 1'b0;
      e_fl   = 1'b0;
      e_busy = m_pend[i] || (m_left[i] > 0);
      if (r) begin
        e_fl = 1'b0;
      end else if (m_pend[i]) begin
        e_vld = 1'b1;
        e_fl  = 1'b1;
      end else if (m_left[i] > 0) begin
        e_fl = 1'b1;
      end else begin
        e_fl = fc;
      end
      chk("redirect_vld", i, {31'd0, vld[i]}, {31'd0, e_vld});
      chk("redirect_pc",  i, pc[i], m_pc[i]);
      chk("flush_ifid",   i, {31'd0, fi[i]}, {31'd0, e_fl});
      chk("flush_idex",   i, {31'd0, fx[i]}, {31'd0, e_fl});
      chk("busy",         i, {31'd0, bsy[i]}, {31'd0, e_busy});
      chk("redirect_cnt", i, 32'(rc[i]), 32'(stat_exp(m_rc[i])));
      chk("squash_cnt",   i, 32'(sc[i]), 32'(stat_exp(m_sc[i])));
      if (!r) begin
        if (e_fl) m_sc[i]++;
        if (m_pend[i]) begin
          if (rdy) begin
            m_pend[i] = 1'b0;
            m_left[i] = flcyc[i] - 1;
            m_rc[i]++;
          end
        end else if (m_left[i] > 0) begin
          m_left[i]--;
        end else if (fc) begin
          m_pend[i] = 1'b1;
          m_pc[i]   = a;
        end
      end
    end
  endtask

  typedef struct {
    logic        fc;
    logic [31:0] a;
    logic        rdy;
    logic        e_vld;
    logic [31:0] e_pc;
    logic        e_fl;
    logic        e_busy;
  } vec_t;

  vec_t tbl[13];

  initial begin
    int fcnt[NI];

    // Basic flow, wrong-path suppression, then 5 cycles of backpressure (FLUSH_CYCLES=2 instance).
    tbl[0]  = '{1'b1, 32'h100, 1'b1, 1'b0, 32'h000, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 32'h000, 1'b1, 1'b1, 32'h100, 1'b1, 1'b1};
    tbl[2]  = '{1'b1, 32'h200, 1'b1, 1'b0, 32'h100, 1'b1, 1'b1};
    tbl[3]  = '{1'b0, 32'h000, 1'b1, 1'b0, 32'h100, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 32'h300, 1'b0, 1'b0, 32'h100, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 32'h200, 1'b0, 1'b1, 32'h300, 1'b1, 1'b1};
    tbl[6]  = '{1'b1, 32'h200, 1'b0, 1'b1, 32'h300, 1'b1, 1'b1};
    tbl[7]  = '{1'b1, 32'h200, 1'b0, 1'b1, 32'h300, 1'b1, 1'b1};
    tbl[8]  = '{1'b1, 32'h200, 1'b0, 1'b1, 32'h300, 1'b1, 1'b1};
    tbl[9]  = '{1'b1, 32'h200, 1'b0, 1'b1, 32'h300, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 32'h000, 1'b1, 1'b1, 32'h300, 1'b1, 1'b1};
    tbl[11] = '{1'b0, 32'h000, 1'b0, 1'b0, 32'h300, 1'b1, 1'b1};
    tbl[12] = '{1'b0, 32'h000, 1'b0, 1'b0, 32'h300, 1'b0, 1'b0};

    model_reset();
    repeat (2) @(negedge clk);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < NI; i++) begin
      chk("rst_vld",  i, {31'd0, vld[i]}, 32'd0);
      chk("rst_pc",   i, pc[i], 32'd0);
      chk("rst_busy", i, {31'd0, bsy[i]}, 32'd0);
    end

    for (int k = 0; k < 13; k++) begin
      step(tbl[k].fc, tbl[k].a, tbl[k].rdy, 1'b0);
      chk("tbl_vld",   k, {31'd0, vld[0]}, {31'd0, tbl[k].e_vld});
      chk("tbl_pc",    k, pc[0], tbl[k].e_pc);
      chk("tbl_flush", k, {31'd0, fx[0]}, {31'd0, tbl[k].e_fl});
      chk("tbl_busy",  k, {31'd0, bsy[0]}, {31'd0, tbl[k].e_busy});
    end

    // Let every instance drain, then count flush cycles from the transfer onward.
    repeat (6) step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 32'h400, 1'b1, 1'b0);
    for (int i = 0; i < NI; i++) fcnt[i] = 0;
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 32'h0, 1'b1, 1'b0);
      for (int i = 0; i < NI; i++) if (fx[i]) fcnt[i]++;
    end
    for (int i = 0; i < NI; i++) chk("flush_cycles", i, 32'(fcnt[i]), 32'(flcyc[i]));

    // Reset while a redirect is pending.
    step(1'b1, 32'h100, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < NI; i++) begin
      chk("midrst_vld",  i, {31'd0, vld[i]}, 32'd0);
      chk("midrst_busy", i, {31'd0, bsy[i]}, 32'd0);
      chk("midrst_pc",   i, pc[i], 32'd0);
    end
    step(1'b0, 32'h0, 1'b0, 1'b0);

    // Twenty back-to-back redirects push the 4-bit counters into saturation.
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 32'h1000 + 32'(k * 4), 1'b1, 1'b0);
      repeat (5) step(1'b0, 32'h0, 1'b1, 1'b0);
    end
    for (int i = 0; i < NI; i++) begin
      chk("redirect_cnt_sat", i, 32'(rc[i]), STATS ? 32'd15 : 32'd0);
      chk("squash_cnt_sat",   i, 32'(sc[i]), STATS ? 32'd15 : 32'd0);
    end

    // Random traffic with occasional asynchronous reset.
    for (int k = 0; k < 400; k++) begin
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 99) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
